rom_dl_router: RTL
==================

Name: rom_dl_router

Overview:
- Parametrised successor to the per-ROM download decode in the arcade top level.
- Takes the hps_io ioctl byte stream for one ioctl_index and routes each byte to one of NCH ROM channels, selected by a base/size window per channel.
- Packs bytes into DW-bit words with per-lane byte enables. Flushes a partial trailing word when the download ends. Reports per-channel completion and the count of unmapped bytes.
- Sits between hps_io and the core's dpram ROM instances.

Parameters:
- NCH, 4: number of ROM channels, 1..8.
- DW, 8: output word width; 8, 16 or 32.
- AW, 16: output word-address width, shared by all channels.
- INDEX, 0: ioctl_index value this block accepts.
- BASE, {NCH{25'h0}}: packed 25-bit byte base per channel; channel 0 is in the LSBs. Each base is aligned to DW/8.
- SIZE_LOG2, {NCH{5'd12}}: packed 5-bit log2 of window size in bytes per channel; log2(DW/8) <= value <= AW+log2(DW/8).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download active, from hps_io
- ioctl_index  in  8  download index
- ioctl_wr  in  1  byte strobe, one cycle per byte
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ch_wr  out  NCH  one-hot write strobe
- ch_addr  out  AW  word address within the selected channel window
- ch_data  out  DW  packed word; lane k = byte (addr & (DW/8-1)) == k
- ch_be  out  DW/8  valid lanes of ch_data
- dl_busy  out  1  high in LOAD and FLUSH
- dl_done  out  1  one-cycle pulse at end of an accepted download
- ch_loaded  out  NCH  channel received at least 2^SIZE_LOG2 bytes this download
- unmapped_cnt  out  8  saturating count of accepted bytes outside all windows

Behaviour:
- Reset: all outputs are 0, state IDLE, pending word invalid.
- Lane width: L = log2(DW/8), with L = 0 for DW = 8.
- States and transitions:
  - IDLE -> LOAD on ioctl_download = 1 with ioctl_index == INDEX. On entry, ch_loaded, unmapped_cnt and the byte counters clear.
  - LOAD -> FLUSH on ioctl_download = 0.
  - FLUSH lasts 1 cycle -> DONE.
  - DONE lasts 1 cycle with dl_done = 1 -> IDLE.
  - A download with a different index is ignored entirely; the block stays in IDLE.
- Decode per accepted byte (ioctl_wr in LOAD):
  - Channel c hits when BASE[c] <= addr < BASE[c] + 2^SIZE_LOG2[c].
  - Lowest hitting channel wins.
  - No hit: unmapped_cnt increments, saturating at 255. The byte is dropped and does not disturb the pending word.
- Packing:
  - The pending register holds {channel, word address = (addr - BASE[c]) >> L, data, be}.
  - A hit byte whose {channel, word address} equals the pending word merges into its lane and sets that be bit.
  - A hit byte that differs from a valid pending word emits the pending word, and the byte then starts a new pending word.
  - When the merged byte completes all lanes (be all ones), the word emits and the pending word becomes invalid.
- Emission:
  - Outputs are registered and appear the cycle after the triggering ioctl_wr.
  - ch_wr is high for exactly one cycle; ch_addr, ch_data and ch_be are valid in that cycle.
  - At most one emission per cycle.
  - Lanes not written are 0 in ch_data.
- DW = 8: every hit byte emits with 1-cycle latency and ch_be = 1.
- FLUSH: a valid pending word emits in the FLUSH cycle with its partial ch_be; otherwise ch_wr stays 0.
- Completion: each per-channel byte counter saturates at 2^SIZE_LOG2. ch_loaded[c] sets when the counter reaches that value and holds until the next accepted download.
- ioctl_wr outside LOAD is ignored.
- Reset mid-download: immediate return to IDLE. The pending word is discarded, and no ch_wr or dl_done is produced.
- ioctl_download falling while in IDLE is ignored.

Decomposition:
- Shared package rom_dl_pkg:
  - state enum {IDLE, LOAD, FLUSH, DONE}
  - function that extracts BASE/SIZE_LOG2 fields
  - elaboration-time check of base alignment and size range
- One natural sub-module: rom_dl_packer. It holds the pending register, lane merge and emit logic for one DW.

Test Plan:
- NCH=3, DW=8; BASE={0,'hE000,'hFF00}, SIZE_LOG2={15,12,8}.
  - Stream 'h0000..'h10FFF -> ch_wr[0] asserted 32768 times, ch_wr[1] 4096 times, ch_wr[2] 256 times.
  - Same stream -> ch_loaded = 3'b111.
  - Same stream -> unmapped_cnt = 255 (saturated).
  - Same stream -> dl_done pulses once, 2 cycles after ioctl_download falls.
- DW=16, one channel with base 0: bytes 'h12 @0, 'h34 @1 -> a single ch_wr with ch_addr=0, ch_data='h3412, ch_be=2'b11.
- DW=32: 5 bytes at 0..4, then download ends -> first word emits with be=4'hF. Word at address 1 then emits in FLUSH with be=4'b0001 and data 'h000000xx.
- Overlapping windows, ch0 and ch1 both covering 'h100 -> only ch_wr[0] fires.
- Download with ioctl_index=1 while INDEX=0 -> ch_wr, dl_busy and dl_done all stay 0.
- reset_n low for 1 cycle after 3 bytes with DW=32 -> no ch_wr and no dl_done. The next download starts with ch_loaded=0 and unmapped_cnt=0.

Source files
------------

// File: rtl/rom_dl_pkg.sv
// Shared types and parameter helpers for the ROM download router.
package rom_dl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} dl_state_e;

  localparam int MAX_CH = 8;
  // Wide enough for base + window size of any legal configuration.
  localparam int XW = 27;

  function automatic int lane_bits(input int dw);
    return (dw == 32) ? 2 : (dw == 16) ? 1 : 0;
  endfunction

  function automatic logic [24:0] base_of(input logic [MAX_CH*25-1:0] v, input int c);
    return v[c*25 +: 25];
  endfunction

  function automatic logic [4:0] size_of(input logic [MAX_CH*5-1:0] v, input int c);
    return v[c*5 +: 5];
  endfunction

  // Window length in bytes for channel c.
  function automatic logic [XW-1:0] win_bytes(input logic [MAX_CH*5-1:0] v, input int c);
    return XW'(1) << v[c*5 +: 5];
  endfunction

  // Bases must be word aligned and every window must fit the word-address range.
  function automatic bit cfg_ok(input logic [MAX_CH*25-1:0] b, input logic [MAX_CH*5-1:0] s,
                                input int nch, input int dw, input int aw);
    int l;
    bit ok;
    l  = lane_bits(dw);
    ok = (nch >= 1) && (nch <= MAX_CH) && (dw == 8 || dw == 16 || dw == 32);
    for (int c = 0; c < MAX_CH; c++) begin
      if (c < nch) begin
        if ((b[c*25 +: 25] & ((25'd1 << l) - 25'd1)) != 25'd0) ok = 1'b0;
        if (int'(s[c*5 +: 5]) < l || int'(s[c*5 +: 5]) > aw + l) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/rom_dl_packer.sv
// Byte-to-word packer: one pending word, lane merge, registered single emit.
module rom_dl_packer
  import rom_dl_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 16,
  parameter int CHW = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [CHW-1:0]    in_ch,
  input  logic [AW-1:0]     in_addr,
  input  logic [((lane_bits(DW) > 0) ? lane_bits(DW) : 1)-1:0] in_lane,
  input  logic [7:0]        in_byte,
  input  logic              flush,
  output logic              emit,
  output logic [CHW-1:0]    emit_ch,
  output logic [AW-1:0]     emit_addr,
  output logic [DW-1:0]     emit_data,
  output logic [DW/8-1:0]   emit_be
);

  localparam int LANES = DW / 8;

  logic                      pend_v, pend_v_nxt;
  logic [CHW-1:0]            pend_ch, pend_ch_nxt;
  logic [AW-1:0]             pend_addr, pend_addr_nxt;
  logic [LANES-1:0][7:0]     pend_data, pend_data_nxt;
  logic [LANES-1:0]          pend_be, pend_be_nxt;

  logic                      same, full;
  logic [LANES-1:0][7:0]     m_data;
  logic [LANES-1:0]          m_be;
  logic                      e_v;
  logic [CHW-1:0]            e_ch;
  logic [AW-1:0]             e_addr;
  logic [LANES-1:0][7:0]     e_data;
  logic [LANES-1:0]          e_be;

  // Merge the incoming byte and pick the (at most one) word to emit this cycle.
  always_comb begin
    same   = pend_v && (pend_ch == in_ch) && (pend_addr == in_addr);
    m_data = same ? pend_data : '0;
    m_be   = same ? pend_be   : '0;
    m_data[in_lane] = in_byte;
    m_be[in_lane]   = 1'b1;
    full   = &m_be;

    pend_v_nxt    = pend_v;
    pend_ch_nxt   = pend_ch;
    pend_addr_nxt = pend_addr;
    pend_data_nxt = pend_data;
    pend_be_nxt   = pend_be;
    e_v    = 1'b0;
    e_ch   = pend_ch;
    e_addr = pend_addr;
    e_data = pend_data;
    e_be   = pend_be;

    if (wr) begin
      if (pend_v && !same) begin
        // Old word leaves now; the new byte starts a fresh word (flushed later if needed).
        e_v           = 1'b1;
        pend_v_nxt    = 1'b1;
        pend_ch_nxt   = in_ch;
        pend_addr_nxt = in_addr;
        pend_data_nxt = m_data;
        pend_be_nxt   = m_be;
      end else if (full || flush) begin
        e_v        = 1'b1;
        e_ch       = in_ch;
        e_addr     = in_addr;
        e_data     = m_data;
        e_be       = m_be;
        pend_v_nxt = 1'b0;
      end else begin
        pend_v_nxt    = 1'b1;
        pend_ch_nxt   = in_ch;
        pend_addr_nxt = in_addr;
        pend_data_nxt = m_data;
        pend_be_nxt   = m_be;
      end
    end else if (flush && pend_v) begin
      e_v        = 1'b1;
      pend_v_nxt = 1'b0;
    end
  end

  // Pending word and registered emit port.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_v    <= 1'b0;
      pend_ch   <= '0;
      pend_addr <= '0;
      pend_data <= '0;
      pend_be   <= '0;
      emit      <= 1'b0;
      emit_ch   <= '0;
      emit_addr <= '0;
      emit_data <= '0;
      emit_be   <= '0;
    end else begin
      pend_v    <= pend_v_nxt;
      pend_ch   <= pend_ch_nxt;
      pend_addr <= pend_addr_nxt;
      pend_data <= pend_data_nxt;
      pend_be   <= pend_be_nxt;
      emit      <= e_v;
      emit_ch   <= e_v ? e_ch   : '0;
      emit_addr <= e_v ? e_addr : '0;
      emit_data <= e_v ? e_data : '0;
      emit_be   <= e_v ? e_be   : '0;
    end
  end

endmodule

// File: rtl/rom_dl_router.sv
// Routes one hps_io download index to NCH ROM windows as packed DW-bit words.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int              NCH       = 4,
  parameter int              DW        = 8,
  parameter int              AW        = 16,
  parameter int              INDEX     = 0,
  parameter logic [NCH*25-1:0] BASE    = '0,
  parameter logic [NCH*5-1:0]  SIZE_LOG2 = {NCH{5'd12}}
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  output logic [NCH-1:0]   ch_wr,
  output logic [AW-1:0]    ch_addr,
  output logic [DW-1:0]    ch_data,
  output logic [DW/8-1:0]  ch_be,
  output logic             dl_busy,
  output logic             dl_done,
  output logic [NCH-1:0]   ch_loaded,
  output logic [7:0]       unmapped_cnt
);

  localparam int L   = lane_bits(DW);
  localparam int LW  = (L > 0) ? L : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [MAX_CH*25-1:0] BASE_X = (MAX_CH*25)'(BASE);
  localparam logic [MAX_CH*5-1:0]  SIZE_X = (MAX_CH*5)'(SIZE_LOG2);

  generate
    if (!cfg_ok(BASE_X, SIZE_X, NCH, DW, AW)) begin : g_bad_cfg
      $error("rom_dl_router: illegal NCH/DW/BASE/SIZE_LOG2 configuration");
    end
  endgenerate

  dl_state_e            state, state_nxt;
  logic                 start, acc, flush;
  logic                 hit_any;
  logic [CHW-1:0]       hit_ch;
  logic [AW-1:0]        hit_waddr;
  logic [LW-1:0]        lane;
  logic [NCH-1:0][XW-1:0] cnt;
  logic                 emit;
  logic [CHW-1:0]       emit_ch;

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: only a download for our index leaves IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ioctl_download && ioctl_index == 8'(INDEX)) state_nxt = LOAD;
      LOAD:    if (!ioctl_download) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start   = (state == IDLE) && (state_nxt == LOAD);
  assign acc     = (state == LOAD) && ioctl_wr;
  // Flush starts on the cycle the download drops so the tail word lands in FLUSH.
  assign flush   = ((state == LOAD) && !ioctl_download) || (state == FLUSH);
  assign dl_busy = (state == LOAD) || (state == FLUSH);
  assign dl_done = (state == DONE);
  assign lane    = (L == 0) ? '0 : ioctl_addr[LW-1:0];

  // Window decode; scanning downward leaves the lowest hitting channel.
  always_comb begin
    logic [XW-1:0] a, b;
    hit_any   = 1'b0;
    hit_ch    = '0;
    hit_waddr = '0;
    a         = XW'(ioctl_addr);
    for (int c = NCH - 1; c >= 0; c--) begin
      b = XW'(base_of(BASE_X, c));
      if (a >= b && a < b + win_bytes(SIZE_X, c)) begin
        hit_any   = 1'b1;
        hit_ch    = CHW'(c);
        hit_waddr = AW'((a - b) >> L);
      end
    end
  end

  // Per-download bookkeeping: byte counters, loaded flags, unmapped count.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      ch_loaded    <= '0;
      unmapped_cnt <= '0;
    end else if (start) begin
      cnt          <= '0;
      ch_loaded    <= '0;
      unmapped_cnt <= '0;
    end else if (acc) begin
      if (!hit_any) begin
        if (unmapped_cnt != 8'hFF) unmapped_cnt <= unmapped_cnt + 8'd1;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (hit_ch == CHW'(c) && cnt[c] != win_bytes(SIZE_X, c)) begin
            cnt[c] <= cnt[c] + XW'(1);
            if (cnt[c] + XW'(1) == win_bytes(SIZE_X, c)) ch_loaded[c] <= 1'b1;
          end
        end
      end
    end
  end

  rom_dl_packer #(.DW(DW), .AW(AW), .CHW(CHW)) u_pack (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .wr        (acc && hit_any),
    .in_ch     (hit_ch),
    .in_addr   (hit_waddr),
    .in_lane   (lane),
    .in_byte   (ioctl_dout),
    .flush     (flush),
    .emit      (emit),
    .emit_ch   (emit_ch),
    .emit_addr (ch_addr),
    .emit_data (ch_data),
    .emit_be   (ch_be)
  );

  // One-hot strobe from the registered channel index.
  always_comb begin
    ch_wr = '0;
    for (int c = 0; c < NCH; c++) ch_wr[c] = emit && (emit_ch == CHW'(c));
  end

endmodule
